// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: queues operation commands, drives a combinational ALU,
// captures its result after a programmable settling time and returns it with
// a sequence tag over a valid/ready response channel.
module alu_cmd_issuer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned OP_W       = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [WIDTH-1:0]           cmd_a,
    input  logic [WIDTH-1:0]           cmd_b,
    input  logic [OP_W-1:0]            cmd_op,
    input  logic                       cmd_chain,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [OP_W-1:0]            alu_op,
    input  logic [WIDTH-1:0]           alu_out,
    input  logic                       alu_c,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_out,
    output logic                       rsp_c,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_e;

    // Command FIFO storage and pointers
    logic [WIDTH-1:0] fifo_a_q  [DEPTH];
    logic [WIDTH-1:0] fifo_b_q  [DEPTH];
    logic [OP_W-1:0]  fifo_op_q [DEPTH];
    logic             fifo_ch_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    // FSM and datapath registers
    state_e           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic             rsp_c_q, rsp_c_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == CW'(0));
    assign push       = cmd_valid && !fifo_full;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO payload storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q]  <= cmd_a;
            fifo_b_q[wr_ptr_q]  <= cmd_b;
            fifo_op_q[wr_ptr_q] <= cmd_op;
            fifo_ch_q[wr_ptr_q] <= cmd_chain;
        end
    end

    // FSM next-state, pop decision, ALU drive and capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        acc_d       = acc_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_c_d     = rsp_c_q;
        rsp_tag_d   = rsp_tag_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SW'(1)) begin
                    rsp_out_d   = alu_out;
                    rsp_c_d     = alu_c;
                    acc_d       = alu_out;
                    rsp_tag_d   = tag_q;
                    tag_d       = tag_q + TAG_W'(1);
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Issue the FIFO head to the ALU; chained commands take the accumulator as a
        if (pop) begin
            alu_a_d  = fifo_ch_q[rd_ptr_q] ? acc_q : fifo_a_q[rd_ptr_q];
            alu_b_d  = fifo_b_q[rd_ptr_q];
            alu_op_d = fifo_op_q[rd_ptr_q];
            cnt_d    = SW'(SETTLE_CYC);
        end
    end

    // State, pointer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            acc_q       <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_c_q     <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            acc_q       <= acc_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_c_q     <= rsp_c_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign cmd_ready  = !fifo_full;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_out    = rsp_out_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_tag    = rsp_tag_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != CW'(0));

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator-side companion to the ALU. Buffers operation commands from a producer and drives a, b and op into a combinational ALU. After a programmable settling time it captures out and c, and returns them with a sequence tag over a valid/ready response channel. This is the synthesizable counterpart of the bench-side driver/monitor pair, for use in the DDS calibration datapath.

Parameters:
WIDTH, 4, operand/result width of the ALU.
OP_W, 2, opcode width. Opcode values are passed through uninterpreted.
DEPTH, 4, command FIFO depth; power of two, minimum 2.
SETTLE_CYC, 1, cycles ALU inputs are held before capture; minimum 1.
TAG_W, 4, width of the response sequence tag.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_a  in  WIDTH  operand a
cmd_b  in  WIDTH  operand b
cmd_op  in  OP_W  opcode
cmd_chain  in  1  1 = use last captured result as a, ignoring cmd_a
alu_a  out  WIDTH  registered drive to ALU a
alu_b  out  WIDTH  registered drive to ALU b
alu_op  out  OP_W  registered drive to ALU op
alu_out  in  WIDTH  ALU result, combinational from alu_a/b/op
alu_c  in  1  ALU carry/flag
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_out  out  WIDTH  captured result
rsp_c  out  1  captured carry
rsp_tag  out  TAG_W  sequence number of this response
busy  out  1  FSM not IDLE or FIFO not empty
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): FIFO empty, all registered outputs 0, fifo_count 0, cmd_ready 1, FSM IDLE, tag counter 0, chain accumulator 0.
- FIFO write: occurs on cmd_valid && cmd_ready. When full, cmd_ready is 0 and the command is not written. No write-through: a command written at edge T is poppable no earlier than edge T+1.
- Simultaneous push and pop while not full: both occur and fifo_count is unchanged.
- FSM states:
  - IDLE: if FIFO is non-empty at an edge, pop the command. Load alu_a = chain ? acc : cmd_a, load alu_b and alu_op. Load settle counter = SETTLE_CYC. Go to SETTLE.
  - SETTLE: counter decrements each edge. On the edge where the counter is 1:
    - rsp_out <= alu_out, rsp_c <= alu_c, acc <= alu_out.
    - rsp_tag <= tag, then tag increments, wrapping modulo 2^TAG_W.
    - rsp_valid <= 1; go to RESP.
  - RESP: outputs are held stable while rsp_valid && !rsp_ready. On a handshake edge, rsp_valid <= 0. If the FIFO is non-empty at that same edge, the IDLE pop/load happens immediately (back-to-back) and the FSM goes to SETTLE; otherwise it goes to IDLE.
- alu_a, alu_b and alu_op hold their last values outside SETTLE; they are never glitched.
- Latency with SETTLE_CYC=1 from an idle block: command accepted at edge T, ALU driven after T+1, rsp_valid high after T+2. Steady-state throughput with rsp_ready held high is one response per SETTLE_CYC+1 cycles.
- Chain: acc is updated only at capture. A chained command uses the result of the most recently captured command, even if that response has not yet been handshaken.
- Reset mid-operation: any in-flight and queued commands are discarded and no response is emitted for them. Tags restart at 0.
- busy is combinational: (state != IDLE) || (fifo_count != 0).

Test Plan:
Use a stub ALU where op 0 = a+b, with c = carry.
- Single op: push a=3, b=4, op=0, rsp_ready=1 -> rsp_valid two cycles after accept, rsp_out=7, rsp_c=0, rsp_tag=0.
- Overflow and chain:
  - push a=9, b=8, op=0 -> rsp_out=1, rsp_c=1.
  - then push chain=1, b=2, op=0 -> alu_a=1, rsp_out=3.
- FIFO full / backpressure: rsp_ready=0, push 6 commands back-to-back.
  - Exactly 5 are accepted: 1 held in FSM plus 4 in FIFO.
  - cmd_ready low once fifo_count=4.
  - rsp outputs stay stable until rsp_ready rises.
  - Responses drain in order with tags 0..4.
- Tag wrap: issue 17 commands -> 17th response carries rsp_tag=0.
- SETTLE_CYC=3 build: alu_out stub changes value one cycle after drive -> captured value is the final settled value. Accept-to-valid latency is 4 cycles.
- Reset mid-SETTLE with 2 queued: assert rst_n low -> rsp_valid=0, fifo_count=0, cmd_ready=1 immediately. After release, the next response has rsp_tag=0.
